long_to_double: RTL and testbench

LONG_TO_DOUBLE -- requirements
Module: long_to_double

---
 rtl/long_to_double.sv | 147 ++++++++++++++
 tb/tb_long_to_double.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/long_to_double.sv
// long_to_double: multi-cycle signed 64-bit integer to IEEE-754 binary64 converter.
// Optional `define LONG_TO_DOUBLE_INEXACT_EN adds the long_to_double_inexact flag output.
module long_to_double (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] long_to_double_a,
  input  logic        long_to_double_a_stb,
  output logic        long_to_double_a_ack,
  output logic [63:0] long_to_double_z,
  output logic        long_to_double_z_stb,
  input  logic        long_to_double_z_ack
`ifdef LONG_TO_DOUBLE_INEXACT_EN
  ,
  output logic        long_to_double_inexact
`endif
);

  // state     | meaning
  // GET_A     | idle, a_ack high, waiting for an operand
  // CONVERT   | split sign/magnitude, seed exponent, detect zero
  // NORMALISE | shift magnitude left until bit 63 is set
  // ROUND     | round to nearest, ties to even
  // PACK      | assemble and register the result
  // PUT_Z     | z_stb high, hold z until z_ack
  typedef enum logic [2:0] {GET_A, CONVERT, NORMALISE, ROUND, PACK, PUT_Z} state_t;

  state_t      state_q;
  logic [63:0] a_q;
  logic [63:0] mag_q;
  logic [63:0] z_q;
  logic [10:0] exp_q;
  logic [51:0] man_q;
  logic        sign_q;
  logic        a_ack_q;
  logic        z_stb_q;

  logic [63:0] mag_d;
  logic [52:0] man_d;
  logic        guard;
  logic        rnd;
  logic        sticky;
  logic        round_up;

  assign mag_d    = a_q[63] ? (~a_q + 64'd1) : a_q;
  assign guard    = mag_q[10];
  assign rnd      = mag_q[9];
  assign sticky   = |mag_q[8:0];
  assign round_up = guard & (rnd | sticky | mag_q[11]);
  assign man_d    = {1'b0, mag_q[62:11]} + 53'd1;

  // Normalisation looks one bit ahead so the exit to ROUND costs no extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_q     <= 64'd0;
      mag_q   <= 64'd0;
      z_q     <= 64'd0;
      exp_q   <= 11'd0;
      man_q   <= 52'd0;
      sign_q  <= 1'b0;
      a_ack_q <= 1'b1;
      z_stb_q <= 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (long_to_double_a_stb) begin
            a_q     <= long_to_double_a;
            a_ack_q <= 1'b0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          if (a_q == 64'd0) begin
            sign_q  <= 1'b0;
            mag_q   <= 64'd0;
            exp_q   <= 11'd0;
            man_q   <= 52'd0;
            state_q <= PACK;
          end else begin
            sign_q  <= a_q[63];
            mag_q   <= mag_d;
            exp_q   <= 11'd1086;
            state_q <= mag_d[63] ? ROUND : NORMALISE;
          end
        end
        NORMALISE: begin
          if (mag_q[63]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 11'd1;
            if (mag_q[62]) state_q <= ROUND;
          end
        end
        ROUND: begin
          if (round_up) begin
            man_q <= man_d[51:0];
            if (man_d[52]) exp_q <= exp_q + 11'd1;
          end else begin
            man_q <= mag_q[62:11];
          end
          state_q <= PACK;
        end
        PACK: begin
          z_q     <= {sign_q, exp_q, man_q};
          z_stb_q <= 1'b1;
          state_q <= PUT_Z;
        end
        PUT_Z: begin
          if (long_to_double_z_ack) begin
            z_stb_q <= 1'b0;
            a_ack_q <= 1'b1;
            state_q <= GET_A;
          end
        end
        default: begin
          z_stb_q <= 1'b0;
          a_ack_q <= 1'b1;
          state_q <= GET_A;
        end
      endcase
    end
  end

`ifdef LONG_TO_DOUBLE_INEXACT_EN
  logic inexact_q;
  logic inexact_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inexact_q     <= 1'b0;
      inexact_out_q <= 1'b0;
    end else begin
      if (state_q == CONVERT) inexact_q <= 1'b0;
      if (state_q == ROUND)   inexact_q <= guard | rnd | sticky;
      if (state_q == PACK)    inexact_out_q <= inexact_q;
    end
  end

  assign long_to_double_inexact = inexact_out_q;
`endif

  assign long_to_double_a_ack = a_ack_q;
  assign long_to_double_z     = z_q;
  assign long_to_double_z_stb = z_stb_q;

endmodule

// File: tb/tb_long_to_double.sv
// tb_long_to_double: directed and randomized checks of long_to_double against an arithmetic model.
// Honours LONG_TO_DOUBLE_INEXACT_EN to connect and check the inexact flag.
module tb_long_to_double;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a = 64'd0;
  logic        a_stb = 1'b0;
  logic        a_ack;
  logic [63:0] z;
  logic        z_stb;
  logic        z_ack = 1'b0;
`ifdef LONG_TO_DOUBLE_INEXACT_EN
  logic        inexact;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  long_to_double dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .long_to_double_a     (a),
    .long_to_double_a_stb (a_stb),
    .long_to_double_a_ack (a_ack),
    .long_to_double_z     (z),
    .long_to_double_z_stb (z_stb),
    .long_to_double_z_ack (z_ack)
`ifdef LONG_TO_DOUBLE_INEXACT_EN
    ,
    .long_to_double_inexact (inexact)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Round-to-nearest-even by comparing the discarded remainder against one half ulp.
  function automatic void ref_model(input logic [63:0] x, output logic [63:0] res,
                                    output logic inx, output int lat);
    logic [63:0] m, keep, rem, half;
    logic [10:0] e;
    int p, sh;
    res = 64'd0; inx = 1'b0; lat = 2;
    if (x == 64'd0) return;
    m = x[63] ? (64'd0 - x) : x;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    e   = 11'(1023 + p);
    lat = 3 + (63 - p);
    if (p <= 52) begin
      keep = m << (52 - p);
    end else begin
      sh   = p - 52;
      keep = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 64'd0);
      if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
      if (keep[53]) begin
        keep = keep >> 1;
        e    = e + 11'd1;
      end
    end
    res = {x[63], e, keep[51:0]};
  endfunction

  task automatic run_op(input logic [63:0] x, input int hold, input bit junk,
                        input bit keep_ack, input string tag, output logic [63:0] zo);
    logic [63:0] mz;
    logic        mi;
    int          lat, n;
    ref_model(x, mz, mi, lat);
    n = 0;
    while (!a_ack && n < 200) begin @(posedge clk); #1; n++; end
    check_val({tag, " a_ack idle"}, 64'(a_ack), 64'd1);
    a = x;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    if (junk) begin
      a = {$urandom, $urandom};
      a_stb = 1'b1;
    end
    n = 0;
    while (!z_stb && n < 100) begin @(posedge clk); #1; n++; end
    a_stb = 1'b0;
    zo = z;
    check_val({tag, " latency"}, 64'(n), 64'(lat));
    check_val({tag, " z"}, z, mz);
    check_val({tag, " a_ack busy"}, 64'(a_ack), 64'd0);
`ifdef LONG_TO_DOUBLE_INEXACT_EN
    check_val({tag, " inexact"}, 64'(inexact), 64'(mi));
`endif
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_val({tag, " hold z"}, z, zo);
      check_val({tag, " hold z_stb"}, 64'(z_stb), 64'd1);
      check_val({tag, " hold a_ack"}, 64'(a_ack), 64'd0);
    end
    if (!keep_ack) z_ack = 1'b1;
    @(posedge clk); #1;
    if (!keep_ack) z_ack = 1'b0;
    check_val({tag, " z_stb drop"}, 64'(z_stb), 64'd0);
    check_val({tag, " a_ack back"}, 64'(a_ack), 64'd1);
  endtask

  initial begin
    logic [63:0] zo, x;
    int sh;
    #12;
    check_val("reset z_stb", 64'(z_stb), 64'd0);
    check_val("reset a_ack", 64'(a_ack), 64'd1);
    check_val("reset z", z, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(64'd1, 0, 1'b0, 1'b0, "one", zo);
    check_val("one const", zo, 64'h3FF0000000000000);
    run_op(64'h8000000000000000, 1, 1'b0, 1'b0, "minint", zo);
    check_val("minint const", zo, 64'hC3E0000000000000);
    run_op(64'd0, 0, 1'b1, 1'b0, "zero", zo);
    check_val("zero const", zo, 64'h0000000000000000);
    run_op(64'h0020000000000001, 0, 1'b0, 1'b0, "tie down", zo);
    check_val("tie down const", zo, 64'h4340000000000000);
    run_op(64'h0020000000000003, 0, 1'b0, 1'b0, "tie up", zo);
    check_val("tie up const", zo, 64'h4340000000000002);
    run_op(64'h7FFFFFFFFFFFFFFF, 0, 1'b0, 1'b0, "carry", zo);
    check_val("carry const", zo, 64'h43E0000000000000);
    run_op(64'hFFFFFFFFFFFFFFFF, 10, 1'b1, 1'b0, "stall", zo);
    check_val("stall const", zo, 64'hBFF0000000000000);

    a = 64'd1;
    a_stb = 1'b1;
    @(posedge clk); #1;
    a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_val("midrst z_stb", 64'(z_stb), 64'd0);
    check_val("midrst a_ack", 64'(a_ack), 64'd1);
    check_val("midrst z", z, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_val("postrst z_stb", 64'(z_stb), 64'd0);
    end
    run_op(64'hFFFFFFFFFFFFFFFB, 0, 1'b0, 1'b0, "minus5", zo);
    check_val("minus5 const", zo, 64'hC014000000000000);

    for (int i = 0; i < 40; i++) begin
      x  = {$urandom, $urandom};
      sh = $urandom_range(0, 63);
      x  = x >> sh;
      if ($urandom_range(0, 1) == 1) x = 64'd0 - x;
      if ($urandom_range(0, 15) == 0) x = 64'd0;
      run_op(x, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, "rand", zo);
    end

    z_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x  = {$urandom, $urandom};
      sh = $urandom_range(0, 63);
      x  = x >> sh;
      if ($urandom_range(0, 1) == 1) x = 64'd0 - x;
      run_op(x, 0, 1'($urandom_range(0, 1)), 1'b1, "b2b", zo);
    end
    z_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
